// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round count, round constants, FSM states, word rotation.
package aes_pkg;

  localparam int unsigned AES_NUM_ROUNDS = 10;
  localparam int unsigned AES_KEY_W      = 128;
  localparam int unsigned AES_WORD_W     = 32;

  localparam logic [0:9][7:0] AES_RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    EXPAND = 2'd2
  } kexp_state_t;

  // RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}
  function automatic logic [AES_WORD_W-1:0] rot_word(input logic [AES_WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round constant for key i -> i+1; zero beyond the table so idx 10 never reads past the end
  function automatic logic [7:0] rcon_at(input logic [3:0] i);
    return (i < 4'd10) ? AES_RCON[i] : 8'h00;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (one byte).
module aes_sbox (
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out_c
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sbox_out_c = SBOX[sbox_in];

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule streaming round keys over valid/ready.
// Optional DECRYPT_KEYS_EN: adds inv port and an 11-entry key store for reverse-order output.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [AES_KEY_W-1:0] key_in,
`ifdef DECRYPT_KEYS_EN
  input  logic                 inv,
`endif
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [AES_KEY_W-1:0] rk_out,
  output logic [IDX_W-1:0]     rk_idx,
  output logic                 rk_last,
  output logic                 busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);
  localparam int unsigned      ST_W     = $clog2(NUM_ROUNDS + 1);

  if (NUM_ROUNDS != AES_NUM_ROUNDS) begin : g_bad_rounds
    $error("aes_key_expander: only NUM_ROUNDS = 10 (AES-128) is supported");
  end
  if ((1 << IDX_W) <= NUM_ROUNDS) begin : g_bad_idx_w
    $error("aes_key_expander: IDX_W too narrow for NUM_ROUNDS");
  end

  kexp_state_t          state_q, state_d;
  logic [AES_KEY_W-1:0] rk_out_q, rk_out_d;
  logic [IDX_W-1:0]     rk_idx_q, rk_idx_d;
  logic                 rk_valid_q, rk_valid_d;
  logic                 rk_last_q, rk_last_d;
  logic                 key_ready_q, key_ready_d;
  logic                 busy_q, busy_d;

`ifdef DECRYPT_KEYS_EN
  logic                 inv_q, inv_d;
  logic [AES_KEY_W-1:0] store_q [NUM_ROUNDS+1];
  logic [AES_KEY_W-1:0] store_d [NUM_ROUNDS+1];
  logic [ST_W-1:0]      st_idx_c, st_prev_c;
`endif

  // Next round key from the key currently held in rk_out_q
  logic [AES_WORD_W-1:0] w0_c, w1_c, w2_c, w3_c;
  logic [AES_WORD_W-1:0] rot_c, sub_c, t_c;
  logic [AES_WORD_W-1:0] n0_c, n1_c, n2_c, n3_c;
  logic [AES_KEY_W-1:0]  next_key_c;

  assign {w0_c, w1_c, w2_c, w3_c} = rk_out_q;
  assign rot_c = rot_word(w3_c);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .sbox_in   (rot_c[8*g +: 8]),
      .sbox_out_c(sub_c[8*g +: 8])
    );
  end

  assign t_c        = sub_c ^ {rcon_at(4'(rk_idx_q)), 24'h000000};
  assign n0_c       = w0_c ^ t_c;
  assign n1_c       = w1_c ^ n0_c;
  assign n2_c       = w2_c ^ n1_c;
  assign n3_c       = w3_c ^ n2_c;
  assign next_key_c = {n0_c, n1_c, n2_c, n3_c};

`ifdef DECRYPT_KEYS_EN
  assign st_idx_c  = ST_W'(rk_idx_q);
  assign st_prev_c = ST_W'(rk_idx_q - IDX_W'(1));
`endif

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    rk_out_d   = rk_out_q;
    rk_idx_d   = rk_idx_q;
    rk_valid_d = rk_valid_q;
`ifdef DECRYPT_KEYS_EN
    inv_d      = inv_q;
    store_d    = store_q;
`endif

    case (state_q)
      IDLE: begin
        if (key_valid && key_ready_q) begin
          rk_out_d   = key_in;
          rk_idx_d   = '0;
          rk_valid_d = 1'b1;
          state_d    = STREAM;
`ifdef DECRYPT_KEYS_EN
          inv_d      = inv;
          if (inv) begin
            rk_valid_d = 1'b0;
            state_d    = EXPAND;
          end
`endif
        end
      end

      STREAM: begin
        if (rk_valid_q && rk_ready) begin
`ifdef DECRYPT_KEYS_EN
          if (!inv_q) store_d[st_idx_c] = rk_out_q;
`endif
          if (rk_last_q) begin
            rk_valid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            rk_out_d = next_key_c;
            rk_idx_d = rk_idx_q + IDX_W'(1);
`ifdef DECRYPT_KEYS_EN
            if (inv_q) begin
              rk_out_d = store_q[st_prev_c];
              rk_idx_d = rk_idx_q - IDX_W'(1);
            end
`endif
          end
        end
      end

`ifdef DECRYPT_KEYS_EN
      EXPAND: begin
        store_d[st_idx_c] = rk_out_q;
        if (rk_idx_q == LAST_IDX) begin
          rk_valid_d = 1'b1;
          state_d    = STREAM;
        end else begin
          rk_out_d = next_key_c;
          rk_idx_d = rk_idx_q + IDX_W'(1);
        end
      end
`endif

      default: state_d = IDLE;
    endcase

`ifdef DECRYPT_KEYS_EN
    rk_last_d = rk_valid_d && (inv_d ? (rk_idx_d == '0) : (rk_idx_d == LAST_IDX));
`else
    rk_last_d = rk_valid_d && (rk_idx_d == LAST_IDX);
`endif
    key_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rk_out_q    <= '0;
      rk_idx_q    <= '0;
      rk_valid_q  <= 1'b0;
      rk_last_q   <= 1'b0;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rk_out_q    <= rk_out_d;
      rk_idx_q    <= rk_idx_d;
      rk_valid_q  <= rk_valid_d;
      rk_last_q   <= rk_last_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
    end
  end

`ifdef DECRYPT_KEYS_EN
  // Cleared on reset so an aborted key never survives into the next sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q   <= 1'b0;
      store_q <= '{default: '0};
    end else begin
      inv_q   <= inv_d;
      store_q <= store_d;
    end
  end
`endif

  assign key_ready = key_ready_q;
  assign rk_valid  = rk_valid_q;
  assign rk_out    = rk_out_q;
  assign rk_idx    = rk_idx_q;
  assign rk_last   = rk_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander: FIPS-197 vectors, backpressure, gating, reset abort.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         busy;
`ifdef DECRYPT_KEYS_EN
  logic         inv = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] KA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KC10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KA_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  always #5 clk = ~clk;

  aes_key_expander dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_in   (key_in),
`ifdef DECRYPT_KEYS_EN
    .inv      (inv),
`endif
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .rk_last  (rk_last),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] st(input logic v, input logic l, input logic kr,
                                      input logic b, input logic [3:0] i);
    return 128'({v, l, kr, b, i});
  endfunction

  // Present a key at a negedge; it is taken on the following rising edge
  task automatic send_key(input logic [127:0] k, input bit iv);
    key_in    = k;
    key_valid = 1'b1;
`ifdef DECRYPT_KEYS_EN
    inv       = iv;
`else
    if (iv) chk("inv_unsupported", 128'(iv), 128'd0);
`endif
    @(negedge clk);
    key_valid = 1'b0;
`ifdef DECRYPT_KEYS_EN
    inv       = 1'b0;
`endif
  endtask

  // Consume 11 keys; each cycle the held key must match the next expected one
  task automatic run_stream(input logic [127:0] exp [11], input bit rev,
                            input int unsigned stall_pct, input bit poke);
    int k;
    int e;
    int budget;
    k      = 0;
    budget = 400;
    while (k < 11 && budget > 0) begin
      e = rev ? 10 - k : k;
      chk("rk_out", rk_out, exp[e]);
      chk("status", st(rk_valid, rk_last, key_ready, busy, rk_idx),
          st(1'b1, 1'(k == 10), 1'b0, 1'b1, 4'(e)));
      rk_ready  = ($urandom_range(99) >= stall_pct);
      key_valid = poke && (k < 10);
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (rk_ready) k++;
      budget--;
    end
    if (k < 11) chk("stream_timeout", 128'(k), 128'd11);
    rk_ready  = 1'b0;
    key_valid = 1'b0;
    chk("idle_after", st(rk_valid, rk_last, key_ready, busy, 4'h0),
        st(1'b0, 1'b0, 1'b1, 1'b0, 4'h0));
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    key_in    = '0;
    repeat (3) @(negedge clk);
    chk("reset_status", st(rk_valid, rk_last, key_ready, busy, rk_idx),
        st(1'b0, 1'b0, 1'b1, 1'b0, 4'h0));
    chk("reset_rk_out", rk_out, 128'h0);
    rst = 1'b0;
    @(negedge clk);

    // Full-rate App. A sequence
    send_key(KA, 1'b0);
    run_stream(KA_RK, 1'b0, 0, 1'b0);

    // Random 30% stalls with key_valid poked during STREAM
    send_key(KA, 1'b0);
    run_stream(KA_RK, 1'b0, 30, 1'b1);

    // Back-to-back key at the first IDLE cycle
    send_key(KC, 1'b0);
    chk("kc_idx0", rk_out, KC);
    rk_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("kc_idx10", rk_out, KC10);
    chk("kc_status10", st(rk_valid, rk_last, key_ready, busy, rk_idx),
        st(1'b1, 1'b1, 1'b0, 1'b1, 4'd10));
    @(negedge clk);
    rk_ready = 1'b0;
    chk("kc_idle", st(rk_valid, rk_last, key_ready, busy, 4'h0),
        st(1'b0, 1'b0, 1'b1, 1'b0, 4'h0));

    // Reset while idx 5 is on the bus
    send_key(KA, 1'b0);
    rk_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_idx5", rk_out, KA_RK[5]);
    chk("mid_status5", st(rk_valid, rk_last, key_ready, busy, rk_idx),
        st(1'b1, 1'b0, 1'b0, 1'b1, 4'd5));
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    rk_ready = 1'b0;
    chk("abort_status", st(rk_valid, rk_last, key_ready, busy, rk_idx),
        st(1'b0, 1'b0, 1'b1, 1'b0, 4'h0));
    chk("abort_rk_out", rk_out, 128'h0);
    @(negedge clk);
    send_key(KA, 1'b0);
    run_stream(KA_RK, 1'b0, 0, 1'b0);

`ifdef DECRYPT_KEYS_EN
    // Reverse order: keys built internally, then emitted 10 down to 0
    send_key(KA, 1'b1);
    n = 1;
    while (!rk_valid && n < 40) begin
      chk("expand_busy", st(1'b0, 1'b0, key_ready, busy, 4'h0), st(1'b0, 1'b0, 1'b0, 1'b1, 4'h0));
      @(negedge clk);
      n++;
    end
    chk("inv_latency", 128'(n), 128'd12);
    run_stream(KA_RK, 1'b1, 0, 1'b0);
`else
    n = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
